// File: rtl/controle_luz_advertencia.sv
// Seat-belt warning lamp/buzzer driver: synchronises and filters the alarm
// request, then runs chime -> blink -> steady lamp and counts accepted warnings.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   pedido           warning request (asynchronous to clk)
//   lampada          lamp drive (registered)
//   buzzer           buzzer drive (registered)
//   estado           0 OCIOSO, 1 AVISO_SONORO, 2 PISCANDO, 3 ESTAVEL
//   contador_avisos  accepted warning events, saturating
module controle_luz_advertencia #(
    parameter int CICLOS_POR_TICK = 10,
    parameter int FILTRO          = 3,
    parameter int T_BUZZER        = 4,
    parameter int T_PISCA         = 2,
    parameter int T_PISCAR_MAX    = 16,
    parameter int W_AVISOS        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pedido,
    output logic                lampada,
    output logic                buzzer,
    output logic [1:0]          estado,
    output logic [W_AVISOS-1:0] contador_avisos
);

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        AVISO_SONORO = 2'd1,
        PISCANDO     = 2'd2,
        ESTAVEL      = 2'd3
    } estado_t;

    localparam int T_MAIOR = (T_BUZZER > T_PISCAR_MAX) ? T_BUZZER : T_PISCAR_MAX;
    localparam int W_PRE   = $clog2(CICLOS_POR_TICK + 1);
    localparam int W_F     = $clog2(FILTRO + 1);
    localparam int W_T     = $clog2(T_MAIOR + 1);
    localparam int W_FASE  = $clog2(T_PISCA + 1);

    localparam logic [W_PRE-1:0]  PRE_MAX  = W_PRE'(CICLOS_POR_TICK - 1);
    localparam logic [W_F-1:0]    F_MAX    = W_F'(FILTRO - 1);
    localparam logic [W_T-1:0]    TB_MAX   = W_T'(T_BUZZER - 1);
    localparam logic [W_T-1:0]    TP_MAX   = W_T'(T_PISCAR_MAX - 1);
    localparam logic [W_FASE-1:0] FASE_MAX = W_FASE'(T_PISCA - 1);

    logic              sync1;
    logic              req_s;
    logic [W_F-1:0]    cnt_f;
    logic [W_PRE-1:0]  presc;
    logic [W_T-1:0]    cnt_tick;
    logic [W_FASE-1:0] cnt_fase;
    logic              fase;
    estado_t           st;

    estado_t nxt;
    logic    tick;
    logic    fase_nxt;
    logic    lamp_nxt;
    logic    muda;

    assign tick   = (presc == PRE_MAX);
    assign muda   = (nxt != st);
    assign estado = st;

    // Release acts on the value entering req_s, so the outputs go off two
    // edges after pedido falls; a release always beats a timer transition.
    always_comb begin
        nxt = st;
        unique case (st)
            OCIOSO: begin
                if (req_s && cnt_f == F_MAX)
                    nxt = AVISO_SONORO;
            end
            AVISO_SONORO: begin
                if (!sync1)
                    nxt = OCIOSO;
                else if (tick && cnt_tick == TB_MAX)
                    nxt = PISCANDO;
            end
            PISCANDO: begin
                if (!sync1)
                    nxt = OCIOSO;
                else if (tick && cnt_tick == TP_MAX)
                    nxt = ESTAVEL;
            end
            ESTAVEL: begin
                if (!sync1)
                    nxt = OCIOSO;
            end
            default: nxt = OCIOSO;
        endcase
    end

    // Lamp phase starts lit on entry to PISCANDO and flips every T_PISCA ticks.
    always_comb begin
        fase_nxt = 1'b0;
        if (nxt == PISCANDO) begin
            if (st != PISCANDO)
                fase_nxt = 1'b1;
            else if (tick && cnt_fase == FASE_MAX)
                fase_nxt = ~fase;
            else
                fase_nxt = fase;
        end
    end

    always_comb begin
        lamp_nxt = 1'b0;
        unique case (nxt)
            OCIOSO:       lamp_nxt = 1'b0;
            AVISO_SONORO: lamp_nxt = 1'b1;
            PISCANDO:     lamp_nxt = fase_nxt;
            ESTAVEL:      lamp_nxt = 1'b1;
            default:      lamp_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1           <= 1'b0;
            req_s           <= 1'b0;
            cnt_f           <= '0;
            presc           <= '0;
            cnt_tick        <= '0;
            cnt_fase        <= '0;
            fase            <= 1'b0;
            st              <= OCIOSO;
            lampada         <= 1'b0;
            buzzer          <= 1'b0;
            contador_avisos <= '0;
        end else begin
            sync1 <= pedido;
            req_s <= sync1;

            // Saturates at FILTRO-1 so a long request cannot wrap and re-fire.
            if (!req_s)
                cnt_f <= '0;
            else if (cnt_f != F_MAX)
                cnt_f <= cnt_f + W_F'(1);

            if (st == OCIOSO || nxt == OCIOSO || tick)
                presc <= '0;
            else
                presc <= presc + W_PRE'(1);

            if (muda)
                cnt_tick <= '0;
            else if (st != OCIOSO && tick)
                cnt_tick <= cnt_tick + W_T'(1);

            if (muda)
                cnt_fase <= '0;
            else if (st == PISCANDO && tick)
                cnt_fase <= (cnt_fase == FASE_MAX) ? '0 : cnt_fase + W_FASE'(1);

            if (st == OCIOSO && nxt == AVISO_SONORO && contador_avisos != '1)
                contador_avisos <= contador_avisos + W_AVISOS'(1);

            st      <= nxt;
            fase    <= fase_nxt;
            lampada <= lamp_nxt;
            buzzer  <= (nxt == AVISO_SONORO);
        end
    end

endmodule

// File: tb/tb_controle_luz_advertencia.sv
// Bench for controle_luz_advertencia: directed scenarios plus random request
// patterns, checked against a timeline model of the warning sequence.
module tb_controle_luz_advertencia;

    localparam int T_SOM  = 4 * 10;
    localparam int T_MEIO = 2 * 10;
    localparam int T_BLK  = 16 * 10;

    logic       clk;
    logic       rst_n;
    logic       pedido;
    logic       lampada;
    logic       buzzer;
    logic [1:0] estado;
    logic [7:0] contador_avisos;
    logic       lampada_s;
    logic       buzzer_s;
    logic [1:0] estado_s;
    logic [1:0] cont_s;

    int total = 0;
    int bad   = 0;

    controle_luz_advertencia dut (
        .clk(clk), .rst_n(rst_n), .pedido(pedido),
        .lampada(lampada), .buzzer(buzzer), .estado(estado),
        .contador_avisos(contador_avisos)
    );

    controle_luz_advertencia #(.W_AVISOS(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pedido(pedido),
        .lampada(lampada_s), .buzzer(buzzer_s), .estado(estado_s),
        .contador_avisos(cont_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of pedido samples; a warning starts once the synchronised
    // request has been high for three edges, and the outputs follow from the
    // number of edges elapsed since it started.
    logic [3:0] hist;
    bit         act;
    int         n;
    int         cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = '0;
            act  = 0;
            n    = 0;
            cnt  = 0;
        end else begin
            if (act) begin
                if (!hist[0]) act = 0;
                else n++;
            end else if (hist[1] && hist[2] && hist[3]) begin
                act = 1;
                n   = 0;
                cnt++;
            end
            hist = {hist[2:0], pedido};
        end
    end

    logic [1:0] e_st;
    logic       e_lamp;
    logic       e_buz;
    logic [7:0] e_cnt;
    logic [1:0] e_sat;

    always_comb begin
        e_st   = 2'd0;
        e_lamp = 1'b0;
        e_buz  = 1'b0;
        if (act) begin
            if (n < T_SOM) begin
                e_st   = 2'd1;
                e_lamp = 1'b1;
                e_buz  = 1'b1;
            end else if (n < T_SOM + T_BLK) begin
                e_st   = 2'd2;
                e_lamp = (((n - T_SOM) / T_MEIO) % 2) == 0;
            end else begin
                e_st   = 2'd3;
                e_lamp = 1'b1;
            end
        end
        e_cnt = (cnt > 255) ? 8'd255 : 8'(cnt);
        e_sat = (cnt > 3) ? 2'd3 : 2'(cnt);
    end

    logic [17:0] obs;
    logic [17:0] expv;
    assign obs  = {estado, lampada, buzzer, contador_avisos,
                   estado_s, lampada_s, buzzer_s, cont_s};
    assign expv = {e_st, e_lamp, e_buz, e_cnt,
                   e_st, e_lamp, e_buz, e_sat};

    task automatic test_reset();
        rst_n  = 1'b0;
        pedido = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (obs !== 18'd0) begin
                bad++;
                $display("FAIL reset got=%h want=0", obs);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        pedido = 1'b1;
        for (int i = 1; i <= 225; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL nominal edge=%0d got=%h want=%h", i, obs, expv);
            end
            if (i == 4 || i == 5 || i == 44 || i == 45 || i == 65 || i == 205) begin
                total++;
                if ((i == 4 && estado !== 2'd0) || (i == 5 && estado !== 2'd1) ||
                    (i == 44 && estado !== 2'd1) || (i == 45 && estado !== 2'd2) ||
                    (i == 65 && lampada !== 1'b0) || (i == 205 && estado !== 2'd3)) begin
                    bad++;
                    $display("FAIL nominal_mark edge=%0d estado=%0d lamp=%b",
                             i, estado, lampada);
                end
            end
        end
        total++;
        if (contador_avisos !== 8'd1 || buzzer !== 1'b0 || lampada !== 1'b1) begin
            bad++;
            $display("FAIL nominal_end cnt=%0d buz=%b lamp=%b want 1 0 1",
                     contador_avisos, buzzer, lampada);
        end
    endtask

    task automatic test_reset_mid();
        pedido = 1'b0;
        repeat (4) @(negedge clk);
        pedido = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_mid_run edge=%0d got=%h want=%h", i, obs, expv);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 18'd0 || expv !== 18'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_drop();
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL drop_run edge=%0d got=%h want=%h", i, obs, expv);
            end
        end
        pedido = 1'b0;
        @(negedge clk);
        total++;
        if (estado !== 2'd2) begin
            bad++;
            $display("FAIL drop_edge1 estado=%0d want=2", estado);
        end
        @(negedge clk);
        total++;
        if (estado !== 2'd0 || lampada !== 1'b0 || buzzer !== 1'b0) begin
            bad++;
            $display("FAIL drop_edge2 estado=%0d lamp=%b buz=%b want 0 0 0",
                     estado, lampada, buzzer);
        end
        repeat (3) @(negedge clk);
        pedido = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv || (i == 4 && buzzer !== 1'b0) ||
                (i == 5 && (buzzer !== 1'b1 || contador_avisos !== 8'd2))) begin
                bad++;
                $display("FAIL reassert edge=%0d got=%h want=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_glitch();
        pedido = 1'b0;
        repeat (6) @(negedge clk);
        pedido = 1'b1;
        repeat (2) @(negedge clk);
        pedido = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv || estado !== 2'd0 || lampada !== 1'b0 ||
                contador_avisos !== 8'd2) begin
                bad++;
                $display("FAIL glitch edge=%0d got=%h want=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_priority();
        bit visto2 = 0;
        pedido = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (estado === 2'd2) visto2 = 1;
            total++;
            if (obs !== expv || (i == 44 && estado !== 2'd1) ||
                (i == 45 && estado !== 2'd0)) begin
                bad++;
                $display("FAIL priority edge=%0d got=%h want=%h", i, obs, expv);
            end
            if (i == 43) pedido = 1'b0;
        end
        total++;
        if (visto2) begin
            bad++;
            $display("FAIL priority_never2 saw estado=2 want none");
        end
    endtask

    task automatic test_saturation();
        logic [1:0] tab [5];
        tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n  = 1'b0;
        pedido = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pedido = 1'b1;
            repeat (8) @(negedge clk);
            total++;
            if (cont_s !== tab[k] || obs !== expv) begin
                bad++;
                $display("FAIL saturation req=%0d cnt=%0d want=%0d", k + 1, cont_s, tab[k]);
            end
            pedido = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            int len;
            pedido = 1'($urandom_range(0, 1));
            len    = $urandom_range(1, 250);
            if ($urandom_range(0, 9) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                total++;
                if (obs !== 18'd0) begin
                    bad++;
                    $display("FAIL random_reset seg=%0d got=%h want=0", s, obs);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL random seg=%0d cyc=%0d got=%h want=%h",
                             s, i, obs, expv);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pedido = 1'b0;
        test_reset();
        test_nominal();
        test_reset_mid();
        test_drop();
        test_glitch();
        test_priority();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
